// File: rtl/ti_sbox6_lane_pipe_if.sv
// Handshake and share bus for the TI S-box lane pipeline.
// The rnd signal exists only when TI_REMASK_EN is defined.
interface ti_sbox6_lane_pipe_if #(
  parameter int NLANES = 6,
  parameter int W      = 6
);
  logic                     in_valid;
  logic                     in_ready;
  logic [W*NLANES-1:0]      in_s0;
  logic [W*NLANES-1:0]      in_s1;
  logic [W*NLANES-1:0]      in_s2;
`ifdef TI_REMASK_EN
  logic [2*W*NLANES-1:0]    rnd;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic [W*NLANES-1:0]      out_s0;
  logic [W*NLANES-1:0]      out_s1;
  logic [W*NLANES-1:0]      out_s2;

  modport master (
`ifdef TI_REMASK_EN
    output rnd,
`endif
    output in_valid, in_s0, in_s1, in_s2, out_ready,
    input  in_ready, out_valid, out_s0, out_s1, out_s2
  );

  modport slave (
`ifdef TI_REMASK_EN
    input  rnd,
`endif
    input  in_valid, in_s0, in_s1, in_s2, out_ready,
    output in_ready, out_valid, out_s0, out_s1, out_s2
  );
endinterface

// File: rtl/ti_sbox6_lane_pipe.sv
// Two-stage valid/ready pipeline of NLANES 3-share 6-bit S-box lanes.
// Optional output share refresh with fresh randomness when TI_REMASK_EN is defined.
module ti_sbox6_lane_pipe #(
  parameter int NLANES = 6,
  parameter int W      = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ti_sbox6_lane_pipe_if.slave  bus
);
  localparam int N = W * NLANES;

  if (W != 6) begin : g_w_check
    $error("ti_sbox6_lane_pipe: W must be 6");
  end

  localparam logic [5:0] SBOX [64] = '{
    6'd54, 6'd0,  6'd48, 6'd13, 6'd15, 6'd18, 6'd35, 6'd53,
    6'd63, 6'd25, 6'd45, 6'd52, 6'd3,  6'd20, 6'd33, 6'd41,
    6'd8,  6'd10, 6'd57, 6'd37, 6'd59, 6'd36, 6'd34, 6'd2,
    6'd26, 6'd50, 6'd58, 6'd24, 6'd60, 6'd19, 6'd14, 6'd42,
    6'd46, 6'd61, 6'd5,  6'd49, 6'd31, 6'd11, 6'd28, 6'd4,
    6'd12, 6'd30, 6'd55, 6'd22, 6'd9,  6'd6,  6'd32, 6'd23,
    6'd27, 6'd39, 6'd21, 6'd17, 6'd16, 6'd29, 6'd62, 6'd1,
    6'd40, 6'd47, 6'd51, 6'd56, 6'd7,  6'd43, 6'd38, 6'd44
  };

  // Algebraic normal form of the S-box: coefficient vector per monomial mask.
  function automatic logic [383:0] calc_anf();
    logic [383:0] a;
    for (int m = 0; m < 64; m++) a[6*m +: 6] = SBOX[m];
    for (int i = 0; i < 6; i++)
      for (int m = 0; m < 64; m++)
        if (m[i]) a[6*m +: 6] = a[6*m +: 6] ^ a[6*(m - (1 << i)) +: 6];
    return a;
  endfunction

  localparam logic [383:0] ANF = calc_anf();

  // Each monomial is expanded over the shares of its variables; every cross
  // term is owned by the share feeding its lowest-index variable.
  function automatic logic [17:0] ti_comp(input logic [5:0] x0, input logic [5:0] x1,
                                          input logic [5:0] x2);
    logic [5:0] f0, f1, f2, msk;
    logic [1:0] sel, own;
    logic       trm, found;
    f0 = '0; f1 = '0; f2 = '0;
    for (int t = 0; t < 4096; t++) begin
      msk = '0; trm = 1'b1; own = 2'd0; found = 1'b0;
      for (int i = 0; i < 6; i++) begin
        sel = 2'((t >> (2*i)) & 3);
        if (sel != 2'd3) begin
          msk[i] = 1'b1;
          case (sel)
            2'd0:    trm = trm & x0[i];
            2'd1:    trm = trm & x1[i];
            default: trm = trm & x2[i];
          endcase
          if (!found) begin
            own   = sel;
            found = 1'b1;
          end
        end
      end
      if (trm) begin
        case (own)
          2'd0:    f0 = f0 ^ ANF[6*int'(msk) +: 6];
          2'd1:    f1 = f1 ^ ANF[6*int'(msk) +: 6];
          default: f2 = f2 ^ ANF[6*int'(msk) +: 6];
        endcase
      end
    end
    return {f2, f1, f0};
  endfunction

  logic         va, vb, adv_a, load_a, load_b;
  logic [N-1:0] a_s0, a_s1, a_s2;
  logic [N-1:0] b_s0, b_s1, b_s2;
  logic [N-1:0] f_s0, f_s1, f_s2;

  assign adv_a        = ~vb | bus.out_ready;
  assign bus.in_ready = ~va | adv_a;
  assign load_a       = bus.in_valid & bus.in_ready;
  assign load_b       = va & adv_a;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    logic [17:0] f;
    always_comb f = ti_comp(a_s0[W*k +: W], a_s1[W*k +: W], a_s2[W*k +: W]);
`ifdef TI_REMASK_EN
    logic [W-1:0] r0, r1;
    assign r0 = bus.rnd[2*W*k +: W];
    assign r1 = bus.rnd[2*W*k + W +: W];
    assign f_s0[W*k +: W] = f[5:0]   ^ r0;
    assign f_s1[W*k +: W] = f[11:6]  ^ r1;
    assign f_s2[W*k +: W] = f[17:12] ^ r0 ^ r1;
`else
    assign f_s0[W*k +: W] = f[5:0];
    assign f_s1[W*k +: W] = f[11:6];
    assign f_s2[W*k +: W] = f[17:12];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va   <= 1'b0;
      vb   <= 1'b0;
      a_s0 <= '0;
      a_s1 <= '0;
      a_s2 <= '0;
      b_s0 <= '0;
      b_s1 <= '0;
      b_s2 <= '0;
    end else begin
      if (load_a) begin
        va   <= 1'b1;
        a_s0 <= bus.in_s0;
        a_s1 <= bus.in_s1;
        a_s2 <= bus.in_s2;
      end else if (load_b) begin
        va <= 1'b0;
      end
      if (load_b) begin
        vb   <= 1'b1;
        b_s0 <= f_s0;
        b_s1 <= f_s1;
        b_s2 <= f_s2;
      end else if (bus.out_ready) begin
        vb <= 1'b0;
      end
    end
  end

  assign bus.out_valid = vb;
  assign bus.out_s0    = b_s0;
  assign bus.out_s1    = b_s1;
  assign bus.out_s2    = b_s2;
endmodule

// File: tb/tb_ti_sbox6_lane_pipe.sv
// Self-checking bench for ti_sbox6_lane_pipe: table vectors, exhaustive random
// share splits, backpressure, mid-run reset, stall hold and remask behaviour.
module tb_ti_sbox6_lane_pipe;
  localparam int NL = 6;
  localparam int N  = 6 * NL;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ti_sbox6_lane_pipe_if #(.NLANES(NL), .W(6)) bus ();

  ti_sbox6_lane_pipe #(.NLANES(NL), .W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int S_TAB [64] = '{54,0,48,13,15,18,35,53,63,25,45,52,3,20,33,41,8,10,57,37,59,36,34,2,
                     26,50,58,24,60,19,14,42,46,61,5,49,31,11,28,4,12,30,55,22,9,6,32,23,
                     27,39,21,17,16,29,62,1,40,47,51,56,7,43,38,44};

  typedef struct {
    int          acc;
    logic [N-1:0] expv;
  } ent_t;

  typedef struct {
    logic [5:0] s0;
    logic [5:0] s1;
    logic [5:0] s2;
    logic [5:0] expv;
  } vec_t;

  ent_t         q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           last_acc_cyc = 0;
  int           last_out_cyc = 0;
  logic [N-1:0] last_s0;
  logic         stalled = 1'b0;
  logic [3*N-1:0] stash;
`ifdef TI_REMASK_EN
  logic [2*N-1:0] rnd_val = '0;
`endif

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [N-1:0] sbox_lanes(input logic [N-1:0] x);
    logic [N-1:0] r;
    for (int k = 0; k < NL; k++) r[6*k +: 6] = 6'(S_TAB[x[6*k +: 6]]);
    return r;
  endfunction

  function automatic logic [N-1:0] rand36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[N-1:0];
  endfunction

  task automatic set_rnd();
`ifdef TI_REMASK_EN
    rnd_val = {rand36(), rand36()};
`endif
  endtask

  // One clock cycle: drive, check handshake against the occupancy model, score.
  task automatic drive(input logic iv, input logic [N-1:0] s0, input logic [N-1:0] s1,
                       input logic [N-1:0] s2, input logic [N-1:0] expv,
                       input logic ordy, output logic acc);
    logic exp_ov, exp_ir;
    ent_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_s0     = s0;
    bus.in_s1     = s1;
    bus.in_s2     = s2;
    bus.out_ready = ordy;
`ifdef TI_REMASK_EN
    bus.rnd = rnd_val;
`endif
    #1;
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
    exp_ir = !(q.size() == 2 && !ordy);
    check("out_valid", bus.out_valid, exp_ov);
    check("in_ready", bus.in_ready, exp_ir);
    if (stalled && bus.out_valid)
      check("hold_stable", {bus.out_s2, bus.out_s1, bus.out_s0}, stash);
    stalled = bus.out_valid && !ordy;
    stash   = {bus.out_s2, bus.out_s1, bus.out_s0};
    if (bus.out_valid && ordy) begin
      check("out_has_entry", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("xor_result", bus.out_s0 ^ bus.out_s1 ^ bus.out_s2, e.expv);
        last_out_cyc = cyc;
        last_s0      = bus.out_s0;
      end
    end
    acc = iv && bus.in_ready;
    if (acc) begin
      q.push_back('{cyc, expv});
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 20 && q.size() > 0; i++) drive(1'b0, '0, '0, '0, '0, 1'b1, a);
    check("drain_empty", q.size(), 0);
  endtask

  task automatic send_split(input logic [N-1:0] x, input logic ordy, output logic acc);
    logic [N-1:0] s0, s1;
    s0 = rand36();
    s1 = rand36();
    drive(1'b1, s0, s1, x ^ s0 ^ s1, sbox_lanes(x), ordy, acc);
  endtask

  vec_t         tbl [7];
  logic         a;
  logic [N-1:0] x;
  logic [N-1:0] s0_seen [4];
  int           sent, ndiff;

  initial begin
    tbl[0] = '{6'h15, 6'h2A, 6'h3F, 6'h36};
    tbl[1] = '{6'h3F, 6'h00, 6'h00, 6'd44};
    tbl[2] = '{6'h01, 6'h00, 6'h00, 6'd0};
    tbl[3] = '{6'h0C, 6'h03, 6'h05, 6'd45};
    tbl[4] = '{6'h20, 6'h3F, 6'h3F, 6'd46};
    tbl[5] = '{6'h1F, 6'h12, 6'h12, 6'd42};
    tbl[6] = '{6'h30, 6'h18, 6'h09, 6'd61};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_s0     = '0;
    bus.in_s1     = '0;
    bus.in_s2     = '0;
    bus.out_ready = 1'b0;
`ifdef TI_REMASK_EN
    bus.rnd = '0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_shares", {bus.out_s2, bus.out_s1, bus.out_s0}, 0);
    rst_n = 1'b1;

    // First vector and its latency.
    drive(1'b1, {NL{tbl[0].s0}}, {NL{tbl[0].s1}}, {NL{tbl[0].s2}}, {NL{tbl[0].expv}}, 1'b1, a);
    check("first_accept", a, 1);
    drain();
    check("first_latency", last_out_cyc - last_acc_cyc, 2);

    // Table vectors, back to back.
    for (int i = 0; i < 7; i++) begin
      set_rnd();
      drive(1'b1, {NL{tbl[i].s0}}, {NL{tbl[i].s1}}, {NL{tbl[i].s2}}, {NL{tbl[i].expv}}, 1'b1, a);
    end
    drain();

    // Every unmasked value on every lane, random splits, one per cycle.
    for (int u = 0; u < 64; u++) begin
      for (int k = 0; k < NL; k++) x[6*k +: 6] = 6'((u + 11*k) % 64);
      set_rnd();
      send_split(x, 1'b1, a);
      check("stream_accept", a, 1);
    end
    drain();

    // Backpressure with out_ready pattern 1,0,0,1.
    sent = 0;
    for (int n = 0; n < 200 && (sent < 8 || q.size() > 0); n++) begin
      set_rnd();
      if (sent < 8) begin
        send_split(rand36(), (n % 4 == 0) || (n % 4 == 3), a);
        if (a) sent++;
      end else begin
        drive(1'b0, '0, '0, '0, '0, (n % 4 == 0) || (n % 4 == 3), a);
      end
    end
    check("bp_sent", sent, 8);
    check("bp_empty", q.size(), 0);

    // Held stall of 12 cycles with one vector waiting.
    send_split(rand36(), 1'b0, a);
    for (int i = 0; i < 12; i++) begin
      set_rnd();
      drive(1'b0, '0, '0, '0, '0, 1'b0, a);
    end
    check("stall_no_x", $isunknown({bus.out_valid, bus.in_ready, bus.out_s0,
                                    bus.out_s1, bus.out_s2}), 0);
    drain();

    // Reset with both stages full.
    send_split(rand36(), 1'b0, a);
    send_split(rand36(), 1'b0, a);
    drive(1'b0, '0, '0, '0, '0, 1'b0, a);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_in_ready", bus.in_ready, 1);
    check("rst_mid_shares", {bus.out_s2, bus.out_s1, bus.out_s0}, 0);
    q.delete();
    stalled = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    send_split(rand36(), 1'b1, a);
    check("post_rst_accept", a, 1);
    drain();
    check("post_rst_latency", last_out_cyc - last_acc_cyc, 2);

    // Fixed input 63 on all lanes with different randomness.
    for (int j = 0; j < 4; j++) begin
      set_rnd();
      drive(1'b1, {NL{6'h3F}}, '0, '0, {NL{6'd44}}, 1'b1, a);
      drain();
      s0_seen[j] = last_s0;
    end
    ndiff = 0;
    for (int j = 1; j < 4; j++) if (s0_seen[j] != s0_seen[0]) ndiff++;
`ifdef TI_REMASK_EN
    check("remask_shares_vary", ndiff > 0, 1);
`else
    check("shares_rnd_independent", ndiff, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
